id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
//  ID/EX pipeline register plus operand forwarding and load-use hazard detection.
//  Latches decoded operands and controls from ID, then drives ALU data1/data2/ALUCtrl.
//  Picks the freshest value from EX/MEM or MEM/WB for each operand.
//  Raises a hazard stall toward the PC and IF/ID registers.
// PARAMETERS
//  DW    32  datapath width
//  RAW    5  register-address width
//  OPW    3  ALU control width (000 and, 001 or, 010 add, 011 sub, 100 mul)
// PORTS
//  clk_i         in   1    clock, rising edge
//  rst_i         in   1    reset, asynchronous, active-low
//  stall_i       in   1    global freeze (memory wait); hold all state
//  flush_i       in   1    insert bubble (branch taken)
//  id_rs_data_i  in   DW   RS read data;      id_rt_data_i in DW  RT read data
//  id_imm_i      in   DW   sign-extended immediate
//  id_rs_i/id_rt_i/id_rd_i in RAW  register addresses of the instruction in ID
//  id_aluctrl_i  in   OPW  ALU op;  id_alusrc_i/id_regdst_i in 1  operand/dest selects
//  id_regwrite_i/id_memread_i/id_memwrite_i/id_memtoreg_i in 1  passthrough controls
//  exmem_regwrite_i in 1, exmem_rd_i in RAW, exmem_data_i in DW   EX/MEM writer
//  memwb_regwrite_i in 1, memwb_rd_i in RAW, memwb_data_i in DW   MEM/WB writer
//  data1_o/data2_o out DW  ALU operands;  aluctrl_o out OPW  ALU op
//  store_data_o  out  DW   forwarded RT value for stores
//  wr_addr_o     out  RAW  destination register (RegDst ? rd : rt)
//  regwrite_o/memread_o/memwrite_o/memtoreg_o out 1  registered controls
//  valid_o       out  1    EX slot holds a real instruction
//  hazard_o      out  1    load-use stall request (combinational)
// BEHAVIOUR
//  - rst_i low: all registers cleared at once, so every output is 0 and valid_o=0.
//  - Update priority at posedge: stall_i hold > (flush_i | hazard_o) bubble > load ID.
//  - A bubble clears valid and all controls, and zeroes the data fields.
//  - Latency: 1 clock from ID inputs to registered fields.
//  - Forwarding and operand muxing are combinational on the registered fields.
//  - Operand forward select, evaluated separately for rs_q and rt_q:
//    1. EX/MEM: exmem_regwrite_i & exmem_rd_i!=0 & exmem_rd_i==addr. Wins over MEM/WB.
//    2. MEM/WB: memwb_regwrite_i & memwb_rd_i!=0 & memwb_rd_i==addr.
//    3. Otherwise the latched register data.
//  - Register 0 is never forwarded.
//  - data1_o = fwd(rs). data2_o = alusrc_q ? imm_q : fwd(rt). store_data_o = fwd(rt).
//  - hazard_o = valid_q & memread_q & rt_q!=0 & (rt_q==id_rs_i | rt_q==id_rt_i).
//    Forced 0 while stall_i=1.
//  - No width growth: all outputs are DW; mul truncation is the ALU's concern.
// CONFIGURATION
//  ID_EX_FWD_EN defined: forwarding as above.
//  ID_EX_FWD_EN undefined:
//  - data1_o/data2_o/store_data_o come from latched data only.
//  - hazard_o is also asserted for any RAW against ID/EX (valid & regwrite & wr_addr)
//    or EX/MEM (exmem_regwrite_i & exmem_rd_i) when the matching address is !=0.
//  - MEM/WB is covered by the write-first register file.
// STRUCTURE
//  - ex_stage_pkg holds:
//    - ALU op localparams ALU_AND/OR/ADD/SUB/MUL.
//    - Forward select encoding FWD_NONE=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10.
//    - Bubble reset constants.
//  - Sub-module fwd_unit: combinational. Inputs are addr, exmem/memwb writer fields.
//    Output is a 2-bit select. Instantiated twice (rs, rt).
// TESTING
//  1. rst_i low mid-stream with valid_q=1:
//     same cycle, all outputs 0, valid_o=0, hazard_o=0.
//  2. rs_q=5, exmem_rd_i=5, exmem_regwrite_i=1, exmem_data_i=0x10, id_rs_data=0x99
//     -> data1_o=0x10.
//  3. rs_q=5 matches both writers (exmem 0xAA, memwb 0xBB) -> data1_o=0xAA.
//     With rs_q=0, exmem_rd_i=0 -> data1_o = latched value.
//  4. ID/EX lw, rt_q=8; id_rs_i=8 -> hazard_o=1.
//     Next clock: valid_o=0, regwrite_o=0, memread_o=0.
//  5. stall_i=1 with flush_i=1 and new ID inputs -> all outputs unchanged next clock.
//  6. alusrc=1, imm=0xFFFFFFFC, rt_q=3 forwarded from memwb 0x1234
//     -> data2_o=0xFFFFFFFC, store_data_o=0x1234.
//     With ID_EX_FWD_EN undefined, same setup -> hazard_o=1 on RAW.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared ALU op codes, forward select encoding and bubble constants
//
// Purpose : common definitions for the ID/EX operand stage and its forwarding unit.
// Contents: ALU_AND/OR/ADD/SUB/MUL op codes, fwd_sel_t forward select encoding,
//           bubble constants that an empty EX slot is loaded with.
package ex_stage_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_t;

  // An empty slot carries no valid bit and no side-effecting controls.
  localparam logic BUBBLE_VALID = 1'b0;
  localparam logic BUBBLE_CTRL  = 1'b0;

endpackage

// File: rtl/id_ex_operand_stage_fwd_unit.sv
// rtl/id_ex_operand_stage_fwd_unit.sv - combinational operand forward select
//
// Purpose : pick the freshest producer of one source register.
// Ports   : addr             source register address of the EX instruction
//           exmem_regwrite_i EX/MEM write enable,  exmem_rd_i EX/MEM destination
//           memwb_regwrite_i MEM/WB write enable,  memwb_rd_i MEM/WB destination
//           sel              FWD_EXMEM / FWD_MEMWB / FWD_NONE
module fwd_unit
  import ex_stage_pkg::*;
#(
  parameter int RAW = 5
) (
  input  logic [RAW-1:0] addr,
  input  logic           exmem_regwrite_i,
  input  logic [RAW-1:0] exmem_rd_i,
  input  logic           memwb_regwrite_i,
  input  logic [RAW-1:0] memwb_rd_i,
  output fwd_sel_t       sel
);

  // EX/MEM is younger than MEM/WB, so it is checked first. Register 0 is
  // hard-wired, so a write to it never produces a forward.
  always_comb begin
    sel = FWD_NONE;
    if (exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == addr)) begin
      sel = FWD_EXMEM;
    end else if (memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == addr)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX register with operand forwarding and hazard detection
//
// Purpose : latches the decoded instruction from ID, drives ALU operands/op and
//           store data, and requests a stall of PC and IF/ID on hazards.
// Config  : ID_EX_FWD_EN defined   -> EX/MEM and MEM/WB forwarding, load-use stall only.
//           ID_EX_FWD_EN undefined -> latched data only, stall on any RAW against
//                                     ID/EX or EX/MEM.
// Ports   : clk_i, rst_i (async, active-low), stall_i (hold), flush_i (bubble)
//           id_*      decoded operands, addresses and controls from ID
//           exmem_*   EX/MEM writer;  memwb_* MEM/WB writer
//           data1_o/data2_o/aluctrl_o ALU inputs, store_data_o store value
//           wr_addr_o, regwrite_o/memread_o/memwrite_o/memtoreg_o, valid_o
//           hazard_o  combinational stall request
module id_ex_operand_stage
  import ex_stage_pkg::*;
#(
  parameter int DW  = 32,
  parameter int RAW = 5,
  parameter int OPW = 3
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           stall_i,
  input  logic           flush_i,
  input  logic [DW-1:0]  id_rs_data_i,
  input  logic [DW-1:0]  id_rt_data_i,
  input  logic [DW-1:0]  id_imm_i,
  input  logic [RAW-1:0] id_rs_i,
  input  logic [RAW-1:0] id_rt_i,
  input  logic [RAW-1:0] id_rd_i,
  input  logic [OPW-1:0] id_aluctrl_i,
  input  logic           id_alusrc_i,
  input  logic           id_regdst_i,
  input  logic           id_regwrite_i,
  input  logic           id_memread_i,
  input  logic           id_memwrite_i,
  input  logic           id_memtoreg_i,
  input  logic           exmem_regwrite_i,
  input  logic [RAW-1:0] exmem_rd_i,
  input  logic [DW-1:0]  exmem_data_i,
  input  logic           memwb_regwrite_i,
  input  logic [RAW-1:0] memwb_rd_i,
  input  logic [DW-1:0]  memwb_data_i,
  output logic [DW-1:0]  data1_o,
  output logic [DW-1:0]  data2_o,
  output logic [OPW-1:0] aluctrl_o,
  output logic [DW-1:0]  store_data_o,
  output logic [RAW-1:0] wr_addr_o,
  output logic           regwrite_o,
  output logic           memread_o,
  output logic           memwrite_o,
  output logic           memtoreg_o,
  output logic           valid_o,
  output logic           hazard_o
);

  logic [DW-1:0]  rs_data_q, rt_data_q, imm_q;
  logic [RAW-1:0] rs_q, rt_q, wr_addr_q;
  logic [OPW-1:0] aluctrl_q;
  logic           alusrc_q, regwrite_q, memread_q, memwrite_q, memtoreg_q, valid_q;
  logic [DW-1:0]  rs_val, rt_val;
  logic           load_use;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      wr_addr_q  <= '0;
      aluctrl_q  <= '0;
      alusrc_q   <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      valid_q    <= 1'b0;
    end else if (stall_i) begin
      // memory wait: every field holds
    end else if (flush_i || hazard_o) begin
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      wr_addr_q  <= '0;
      aluctrl_q  <= '0;
      alusrc_q   <= BUBBLE_CTRL;
      regwrite_q <= BUBBLE_CTRL;
      memread_q  <= BUBBLE_CTRL;
      memwrite_q <= BUBBLE_CTRL;
      memtoreg_q <= BUBBLE_CTRL;
      valid_q    <= BUBBLE_VALID;
    end else begin
      rs_data_q  <= id_rs_data_i;
      rt_data_q  <= id_rt_data_i;
      imm_q      <= id_imm_i;
      rs_q       <= id_rs_i;
      rt_q       <= id_rt_i;
      wr_addr_q  <= id_regdst_i ? id_rd_i : id_rt_i;
      aluctrl_q  <= id_aluctrl_i;
      alusrc_q   <= id_alusrc_i;
      regwrite_q <= id_regwrite_i;
      memread_q  <= id_memread_i;
      memwrite_q <= id_memwrite_i;
      memtoreg_q <= id_memtoreg_i;
      valid_q    <= 1'b1;
    end
  end

  // A load in EX cannot supply its result to the instruction now in ID.
  assign load_use = valid_q && memread_q && (rt_q != '0) &&
                    ((rt_q == id_rs_i) || (rt_q == id_rt_i));

`ifdef ID_EX_FWD_EN
  fwd_sel_t rs_sel, rt_sel;

  fwd_unit #(.RAW(RAW)) u_fwd_rs (
    .addr             (rs_q),
    .exmem_regwrite_i (exmem_regwrite_i),
    .exmem_rd_i       (exmem_rd_i),
    .memwb_regwrite_i (memwb_regwrite_i),
    .memwb_rd_i       (memwb_rd_i),
    .sel              (rs_sel)
  );

  fwd_unit #(.RAW(RAW)) u_fwd_rt (
    .addr             (rt_q),
    .exmem_regwrite_i (exmem_regwrite_i),
    .exmem_rd_i       (exmem_rd_i),
    .memwb_regwrite_i (memwb_regwrite_i),
    .memwb_rd_i       (memwb_rd_i),
    .sel              (rt_sel)
  );

  always_comb begin
    case (rs_sel)
      FWD_EXMEM: rs_val = exmem_data_i;
      FWD_MEMWB: rs_val = memwb_data_i;
      default:   rs_val = rs_data_q;
    endcase
    case (rt_sel)
      FWD_EXMEM: rt_val = exmem_data_i;
      FWD_MEMWB: rt_val = memwb_data_i;
      default:   rt_val = rt_data_q;
    endcase
  end

  assign hazard_o = !stall_i && load_use;
`else
  logic idex_raw, exmem_raw;
  logic unused_fwd_inputs;

  assign rs_val = rs_data_q;
  assign rt_val = rt_data_q;

  // Without bypass paths any in-flight writer that ID reads from must drain;
  // MEM/WB is safe because the register file writes before it reads.
  assign idex_raw  = valid_q && regwrite_q && (wr_addr_q != '0) &&
                     ((wr_addr_q == id_rs_i) || (wr_addr_q == id_rt_i));
  assign exmem_raw = exmem_regwrite_i && (exmem_rd_i != '0) &&
                     ((exmem_rd_i == id_rs_i) || (exmem_rd_i == id_rt_i));

  assign hazard_o = !stall_i && (load_use || idex_raw || exmem_raw);

  assign unused_fwd_inputs = ^{rs_q, exmem_data_i, memwb_regwrite_i, memwb_rd_i, memwb_data_i};
`endif

  assign data1_o      = rs_val;
  assign data2_o      = alusrc_q ? imm_q : rt_val;
  assign store_data_o = rt_val;
  assign aluctrl_o    = aluctrl_q;
  assign wr_addr_o    = wr_addr_q;
  assign regwrite_o   = regwrite_q;
  assign memread_o    = memread_q;
  assign memwrite_o   = memwrite_q;
  assign memtoreg_o   = memtoreg_q;
  assign valid_o      = valid_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - self-checking bench for id_ex_operand_stage
module tb_id_ex_operand_stage;
  import ex_stage_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i, stall_i, flush_i;
  logic [31:0] id_rs_data_i, id_rt_data_i, id_imm_i;
  logic [4:0]  id_rs_i, id_rt_i, id_rd_i;
  logic [2:0]  id_aluctrl_i;
  logic        id_alusrc_i, id_regdst_i, id_regwrite_i, id_memread_i, id_memwrite_i, id_memtoreg_i;
  logic        exmem_regwrite_i, memwb_regwrite_i;
  logic [4:0]  exmem_rd_i, memwb_rd_i;
  logic [31:0] exmem_data_i, memwb_data_i;
  logic [31:0] data1_o, data2_o, store_data_o;
  logic [2:0]  aluctrl_o;
  logic [4:0]  wr_addr_o;
  logic        regwrite_o, memread_o, memwrite_o, memtoreg_o, valid_o, hazard_o;

  int n_cmp = 0;
  int n_err = 0;

`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  id_ex_operand_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i), .id_imm_i(id_imm_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
    .id_aluctrl_i(id_aluctrl_i), .id_alusrc_i(id_alusrc_i), .id_regdst_i(id_regdst_i),
    .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
    .id_memwrite_i(id_memwrite_i), .id_memtoreg_i(id_memtoreg_i),
    .exmem_regwrite_i(exmem_regwrite_i), .exmem_rd_i(exmem_rd_i), .exmem_data_i(exmem_data_i),
    .memwb_regwrite_i(memwb_regwrite_i), .memwb_rd_i(memwb_rd_i), .memwb_data_i(memwb_data_i),
    .data1_o(data1_o), .data2_o(data2_o), .aluctrl_o(aluctrl_o), .store_data_o(store_data_o),
    .wr_addr_o(wr_addr_o), .regwrite_o(regwrite_o), .memread_o(memread_o),
    .memwrite_o(memwrite_o), .memtoreg_o(memtoreg_o), .valid_o(valid_o), .hazard_o(hazard_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: the instruction currently sitting in the EX slot.
  typedef struct {
    logic        v;
    logic [4:0]  rs, rt, wa;
    logic [31:0] rsd, rtd, imm;
    logic [2:0]  op;
    logic        src, rw, mr, mw, m2r;
  } slot_t;
  slot_t m;

  function automatic logic [31:0] ref_val(input logic [4:0] a, input logic [31:0] latched);
    if (!FWD) return latched;
    if (exmem_regwrite_i && exmem_rd_i != 0 && exmem_rd_i == a) return exmem_data_i;
    if (memwb_regwrite_i && memwb_rd_i != 0 && memwb_rd_i == a) return memwb_data_i;
    return latched;
  endfunction

  function automatic logic reads(input logic [4:0] a);
    return a != 0 && (a == id_rs_i || a == id_rt_i);
  endfunction

  function automatic logic ref_hazard();
    logic h;
    if (stall_i) return 1'b0;
    h = m.v && m.mr && reads(m.rt);
    if (!FWD) h = h || (m.v && m.rw && reads(m.wa)) || (exmem_regwrite_i && reads(exmem_rd_i));
    return h;
  endfunction

  // Advance one clock, updating the reference from the rules for hold/bubble/load.
  task automatic tick();
    logic hz;
    hz = ref_hazard();
    if (stall_i) begin
    end else if (flush_i || hz) begin
      m = '{default: '0};
    end else begin
      m.v = 1'b1; m.rs = id_rs_i; m.rt = id_rt_i;
      m.wa = id_regdst_i ? id_rd_i : id_rt_i;
      m.rsd = id_rs_data_i; m.rtd = id_rt_data_i; m.imm = id_imm_i; m.op = id_aluctrl_i;
      m.src = id_alusrc_i; m.rw = id_regwrite_i; m.mr = id_memread_i;
      m.mw = id_memwrite_i; m.m2r = id_memtoreg_i;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    stall_i = 0; flush_i = 0;
    id_rs_data_i = 0; id_rt_data_i = 0; id_imm_i = 0;
    id_rs_i = 0; id_rt_i = 0; id_rd_i = 0; id_aluctrl_i = 0;
    id_alusrc_i = 0; id_regdst_i = 0; id_regwrite_i = 0;
    id_memread_i = 0; id_memwrite_i = 0; id_memtoreg_i = 0;
    exmem_regwrite_i = 0; exmem_rd_i = 0; exmem_data_i = 0;
    memwb_regwrite_i = 0; memwb_rd_i = 0; memwb_data_i = 0;
  endtask

  // Present an instruction in ID and clock it into EX.
  task automatic load(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                      input logic [2:0] op, input logic src, input logic dst,
                      input logic rw, input logic mr);
    id_rs_i = rs; id_rt_i = rt; id_rd_i = rd;
    id_rs_data_i = rsd; id_rt_data_i = rtd; id_imm_i = imm;
    id_aluctrl_i = op; id_alusrc_i = src; id_regdst_i = dst;
    id_regwrite_i = rw; id_memread_i = mr; id_memwrite_i = 0; id_memtoreg_i = mr;
    tick();
    id_rs_i = 0; id_rt_i = 0;
  endtask

  task automatic test_reset();
    load(5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, ALU_ADD, 1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (valid_o !== 1'b1) begin n_err++; $display("FAIL reset_pre_valid got=%b want=1", valid_o); end
    #1 rst_i = 0;
    #1;
    m = '{default: '0};
    n_cmp++;
    if ({data1_o, data2_o, store_data_o} !== 96'h0) begin
      n_err++; $display("FAIL reset_data got=%h/%h/%h want=0", data1_o, data2_o, store_data_o);
    end
    n_cmp++;
    if ({aluctrl_o, wr_addr_o, regwrite_o, memread_o, memwrite_o, memtoreg_o, valid_o, hazard_o} !== 14'h0) begin
      n_err++; $display("FAIL reset_ctrl got valid=%b rw=%b hz=%b wa=%0d want all 0", valid_o, regwrite_o, hazard_o, wr_addr_o);
    end
    #1 rst_i = 1;
    tick();
  endtask

  task automatic test_fwd_exmem();
    load(5'd5, 5'd6, 5'd7, 32'h99, 32'h66, 32'h0, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0);
    exmem_regwrite_i = 1; exmem_rd_i = 5; exmem_data_i = 32'h10;
    #1;
    n_cmp++;
    if (data1_o !== (FWD ? 32'h10 : 32'h99)) begin
      n_err++; $display("FAIL fwd_exmem got=%h want=%h", data1_o, FWD ? 32'h10 : 32'h99);
    end
    n_cmp++;
    if (data2_o !== 32'h66) begin n_err++; $display("FAIL fwd_exmem_rt got=%h want=66", data2_o); end
  endtask

  task automatic test_fwd_priority();
    exmem_regwrite_i = 1; exmem_rd_i = 5; exmem_data_i = 32'hAA;
    memwb_regwrite_i = 1; memwb_rd_i = 5; memwb_data_i = 32'hBB;
    #1;
    n_cmp++;
    if (data1_o !== (FWD ? 32'hAA : 32'h99)) begin
      n_err++; $display("FAIL fwd_prio got=%h want=%h", data1_o, FWD ? 32'hAA : 32'h99);
    end
    exmem_regwrite_i = 0;
    #1;
    n_cmp++;
    if (data1_o !== (FWD ? 32'hBB : 32'h99)) begin
      n_err++; $display("FAIL fwd_memwb got=%h want=%h", data1_o, FWD ? 32'hBB : 32'h99);
    end
    clear_inputs();
    load(5'd0, 5'd0, 5'd0, 32'h77, 32'h0, 32'h0, ALU_OR, 1'b0, 1'b1, 1'b0, 1'b0);
    exmem_regwrite_i = 1; exmem_rd_i = 0; exmem_data_i = 32'hAA;
    memwb_regwrite_i = 1; memwb_rd_i = 0; memwb_data_i = 32'hBB;
    #1;
    n_cmp++;
    if (data1_o !== 32'h77) begin n_err++; $display("FAIL fwd_r0 got=%h want=77", data1_o); end
    clear_inputs();
  endtask

  task automatic test_load_use();
    load(5'd4, 5'd8, 5'd0, 32'h1, 32'h2, 32'h4, ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b1);
    id_rs_i = 9; id_rt_i = 10;
    #1;
    n_cmp++;
    if (hazard_o !== 1'b0) begin n_err++; $display("FAIL lu_nomatch got=%b want=0", hazard_o); end
    id_rs_i = 8;
    #1;
    n_cmp++;
    if (hazard_o !== 1'b1) begin n_err++; $display("FAIL lu_match got=%b want=1", hazard_o); end
    tick();
    n_cmp++;
    if ({valid_o, regwrite_o, memread_o} !== 3'b000) begin
      n_err++; $display("FAIL lu_bubble got v/rw/mr=%b%b%b want=000", valid_o, regwrite_o, memread_o);
    end
    clear_inputs();
  endtask

  task automatic test_stall_flush();
    load(5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, ALU_ADD, 1'b0, 1'b1, 1'b1, 1'b0);
    stall_i = 1; flush_i = 1;
    id_rs_i = 3; id_rt_i = 12; id_rd_i = 13; id_rs_data_i = 32'hDEAD; id_rt_data_i = 32'hBEEF;
    id_aluctrl_i = ALU_MUL; id_regwrite_i = 0; id_memread_i = 1;
    #1;
    n_cmp++;
    if (hazard_o !== 1'b0) begin n_err++; $display("FAIL stall_hz got=%b want=0", hazard_o); end
    tick();
    n_cmp++;
    if ({valid_o, regwrite_o, memread_o, wr_addr_o, aluctrl_o} !== {3'b110, 5'd3, ALU_ADD}) begin
      n_err++; $display("FAIL stall_ctrl got v=%b rw=%b mr=%b wa=%0d op=%0d", valid_o, regwrite_o, memread_o, wr_addr_o, aluctrl_o);
    end
    n_cmp++;
    if ({data1_o, data2_o} !== {32'h11, 32'h22}) begin
      n_err++; $display("FAIL stall_data got=%h/%h want=11/22", data1_o, data2_o);
    end
    stall_i = 0;
    tick();
    n_cmp++;
    if ({valid_o, regwrite_o, memread_o, data1_o} !== 35'h0) begin
      n_err++; $display("FAIL flush_bubble got v=%b rw=%b d1=%h want 0", valid_o, regwrite_o, data1_o);
    end
    clear_inputs();
  endtask

  task automatic test_imm_store();
    load(5'd2, 5'd3, 5'd0, 32'h7, 32'h5555, 32'hFFFFFFFC, ALU_SUB, 1'b1, 1'b0, 1'b1, 1'b0);
    memwb_regwrite_i = 1; memwb_rd_i = 3; memwb_data_i = 32'h1234;
    #1;
    n_cmp++;
    if (data2_o !== 32'hFFFFFFFC) begin n_err++; $display("FAIL imm_data2 got=%h want=fffffffc", data2_o); end
    n_cmp++;
    if (store_data_o !== (FWD ? 32'h1234 : 32'h5555)) begin
      n_err++; $display("FAIL store_fwd got=%h want=%h", store_data_o, FWD ? 32'h1234 : 32'h5555);
    end
    id_rt_i = 3;
    #1;
    n_cmp++;
    if (hazard_o !== !FWD) begin n_err++; $display("FAIL raw_idex got=%b want=%b", hazard_o, !FWD); end
    id_rt_i = 9; id_rs_i = 14; exmem_regwrite_i = 1; exmem_rd_i = 14;
    #1;
    n_cmp++;
    if (hazard_o !== !FWD) begin n_err++; $display("FAIL raw_exmem got=%b want=%b", hazard_o, !FWD); end
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      stall_i = ($urandom_range(0, 7) == 0);
      flush_i = ($urandom_range(0, 7) == 0);
      id_rs_data_i = $urandom; id_rt_data_i = $urandom; id_imm_i = $urandom;
      id_rs_i = 5'($urandom_range(0, 7)); id_rt_i = 5'($urandom_range(0, 7));
      id_rd_i = 5'($urandom_range(0, 7)); id_aluctrl_i = 3'($urandom_range(0, 4));
      {id_alusrc_i, id_regdst_i, id_regwrite_i, id_memread_i, id_memwrite_i, id_memtoreg_i} = 6'($urandom);
      exmem_regwrite_i = 1'($urandom); exmem_rd_i = 5'($urandom_range(0, 7)); exmem_data_i = $urandom;
      memwb_regwrite_i = 1'($urandom); memwb_rd_i = 5'($urandom_range(0, 7)); memwb_data_i = $urandom;
      #1;
      n_cmp++;
      if (data1_o !== ref_val(m.rs, m.rsd)) begin
        n_err++; $display("FAIL rnd_data1 i=%0d got=%h want=%h", i, data1_o, ref_val(m.rs, m.rsd));
      end
      n_cmp++;
      if (data2_o !== (m.src ? m.imm : ref_val(m.rt, m.rtd))) begin
        n_err++; $display("FAIL rnd_data2 i=%0d got=%h want=%h", i, data2_o, m.src ? m.imm : ref_val(m.rt, m.rtd));
      end
      n_cmp++;
      if (store_data_o !== ref_val(m.rt, m.rtd)) begin
        n_err++; $display("FAIL rnd_store i=%0d got=%h want=%h", i, store_data_o, ref_val(m.rt, m.rtd));
      end
      n_cmp++;
      if ({valid_o, regwrite_o, memread_o, memwrite_o, memtoreg_o, wr_addr_o, aluctrl_o} !==
          {m.v, m.rw, m.mr, m.mw, m.m2r, m.wa, m.op}) begin
        n_err++; $display("FAIL rnd_ctrl i=%0d got v=%b wa=%0d op=%0d want v=%b wa=%0d op=%0d",
                          i, valid_o, wr_addr_o, aluctrl_o, m.v, m.wa, m.op);
      end
      n_cmp++;
      if (hazard_o !== ref_hazard()) begin
        n_err++; $display("FAIL rnd_hazard i=%0d got=%b want=%b", i, hazard_o, ref_hazard());
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst_i = 0;
    m = '{default: '0};
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1;
    test_reset();
    test_fwd_exmem();
    test_fwd_priority();
    test_load_use();
    test_stall_flush();
    test_imm_store();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
